// File: rtl/adc_uart_tx.sv
// adc_uart_tx: 8N1 UART transmitter for ADC samples with a one-deep pending buffer and overrun pulse.
// Define ADC_UART_HEX_EN to send each sample as four ASCII bytes (hex high, hex low, CR, LF).
module adc_uart_tx #(
  parameter int CLK_HZ = 16000000,
  parameter int BAUD = 115200,
  parameter int ADC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADC_WIDTH-1:0] sample_in,
  input  logic                 sample_rdy,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 overrun
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic rdy_q, buf_full, rise, tick, take, more, line_d, busy_d;
  logic [7:0] buf_q, sh, load_byte;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  assign rise = sample_rdy & ~rdy_q;
  assign tick = baud_cnt == BW'(DIV - 1);
  // The buffer is consumed only when a whole new message begins.
  assign take = buf_full && (state == IDLE || (state == STOP && tick && !more));
  if (ADC_WIDTH > 8) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^sample_in[ADC_WIDTH-9:0];
  end
`ifdef ADC_UART_HEX_EN
  logic [7:0] msg_q;
  logic [1:0] byte_idx;
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  function automatic logic [7:0] msg_byte(input logic [7:0] s, input logic [1:0] i);
    return i == 2'd0 ? hex_char(s[7:4]) : i == 2'd1 ? hex_char(s[3:0]) : i == 2'd2 ? 8'h0D : 8'h0A;
  endfunction
  assign more = byte_idx != 2'd3;
  assign load_byte = take ? msg_byte(buf_q, 2'd0) : msg_byte(msg_q, byte_idx + 2'd1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      msg_q <= '0;
      byte_idx <= '0;
    end else if (take) begin
      msg_q <= buf_q;
      byte_idx <= '0;
    end else if (state == STOP && tick && more) byte_idx <= byte_idx + 2'd1;
`else
  assign more = 1'b0;
  assign load_byte = buf_q;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (buf_full) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && bit_cnt == 3'd7) state_d = STOP;
      STOP:    if (tick) state_d = (more || buf_full) ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Line value for the coming cycle; registered so the pin never glitches.
  always_comb begin
    line_d = state_d == START ? 1'b0 : state_d == DATA ? (tick ? sh[0] : serial_out) : 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rdy_q <= 1'b0;
      buf_q <= '0;
      buf_full <= 1'b0;
      overrun <= 1'b0;
      baud_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      serial_out <= 1'b1;
      busy <= 1'b0;
    end else begin
      rdy_q <= sample_rdy;
      overrun <= rise & buf_full & ~take;
      if (rise) buf_q <= sample_in[ADC_WIDTH-1 -: 8];
      buf_full <= rise | (buf_full & ~take);
      baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + BW'(1);
      bit_cnt <= state != DATA ? '0 : bit_cnt + {2'b0, tick};
      if (take || (state == STOP && tick && more)) sh <= load_byte;
      else if (state_d == DATA && tick) sh <= sh >> 1;
      serial_out <= line_d;
      busy <= busy_d;
    end
endmodule

// File: tb/tb_adc_uart_tx.sv
// tb_adc_uart_tx: randomized self-checking bench for adc_uart_tx with a line receiver and a buffer-level model.
module tb_adc_uart_tx;
  localparam int DIV = 10;
  localparam int FRAME = 10 * DIV;
`ifdef ADC_UART_HEX_EN
  localparam int MSG_LEN = 4;
`else
  localparam int MSG_LEN = 1;
`endif
  localparam int MSG = MSG_LEN * FRAME;
  logic clk = 1'b0, rstn = 1'b1, sample_rdy = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic serial_out, busy, overrun;
  int checks = 0, failures = 0, cyc = 0, ov_cnt = 0;
  logic [8:0] rx_q[$];
  int rx_t[$];
  logic [8:0] mon_r;
  int mon_t;

  adc_uart_tx #(.CLK_HZ(1000), .BAUD(100), .ADC_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .sample_in(sample_in), .sample_rdy(sample_rdy),
    .serial_out(serial_out), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_byte(input logic [7:0] v, input int i);
    string s;
    s = $sformatf("%02X\r\n", v);
    return MSG_LEN == 4 ? s[i] : v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver: detect start, sample each bit mid-cell, record {stop, data} and start cycle.
  initial forever begin
    step(1);
    if (rstn && serial_out === 1'b0) begin
      mon_t = cyc;
      step(DIV / 2 - 1);
      for (int i = 0; i < 9; i++) begin
        step(DIV);
        mon_r[i] = serial_out;
      end
      rx_q.push_back(mon_r);
      rx_t.push_back(mon_t);
    end
  end

  initial forever begin
    step(1);
    if (overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({serial_out, busy, overrun} !== 3'b100) begin
      failures++;
      $display("FAIL reset_state: got line/busy/ovr=%b required 100", {serial_out, busy, overrun});
    end
    step(3);
    rstn = 1'b1;
    for (int k = 0; k < 500; k++) begin
      step(1);
      checks++;
      if ({serial_out, busy} !== 2'b10) begin
        failures++;
        $display("FAIL reset_idle cyc %0d: got line/busy=%b required 10", k, {serial_out, busy});
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] v);
    logic [7:0] b;
    logic el, eb;
    int p;
    sample_in = v;
    sample_rdy = 1'b1;
    step(1);
    sample_rdy = 1'b0;
    checks++;
    if ({serial_out, busy} !== 2'b10) begin
      failures++;
      $display("FAIL frame_edge_n v=%h: got line/busy=%b required 10", v, {serial_out, busy});
    end
    for (int k = 1; k <= MSG + 1; k++) begin
      step(1);
      b = exp_byte(v, (k - 1) / FRAME);
      p = ((k - 1) % FRAME) / DIV;
      el = k > MSG ? 1'b1 : p == 0 ? 1'b0 : p == 9 ? 1'b1 : b[p-1];
      eb = k <= MSG;
      checks++;
      if ({serial_out, busy} !== {el, eb}) begin
        failures++;
        $display("FAIL frame_wave v=%h k=%0d: got line/busy=%b required %b", v, k, {serial_out, busy}, {el, eb});
      end
    end
    step(20);
  endtask

  task automatic test_level(input logic [7:0] v);
    int base;
    base = rx_q.size();
    sample_in = v;
    sample_rdy = 1'b1;
    step(50);
    sample_rdy = 1'b0;
    step(MSG + 60);
    checks++;
    if (rx_q.size() - base != MSG_LEN) begin
      failures++;
      $display("FAIL level_count v=%h: got %0d bytes required %0d", v, rx_q.size() - base, MSG_LEN);
    end else
      for (int i = 0; i < MSG_LEN; i++) begin
        checks++;
        if (rx_q[base+i] !== {1'b1, exp_byte(v, i)}) begin
          failures++;
          $display("FAIL level_byte %0d: got %h required %h", i, rx_q[base+i], {1'b1, exp_byte(v, i)});
        end
      end
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int base, ov0;
    base = rx_q.size();
    ov0 = ov_cnt;
    sample_in = a;
    sample_rdy = 1'b1;
    step(1);
    sample_rdy = 1'b0;
    step(4);
    sample_in = b;
    sample_rdy = 1'b1;
    step(1);
    sample_rdy = 1'b0;
    step(4);
    sample_in = c;
    sample_rdy = 1'b1;
    step(1);
    sample_rdy = 1'b0;
    step(2 * MSG + 50);
    checks++;
    if (ov_cnt - ov0 != 1) begin
      failures++;
      $display("FAIL b2b_overrun: got %0d overrun cycles required 1", ov_cnt - ov0);
    end
    checks++;
    if (rx_q.size() - base != 2 * MSG_LEN) begin
      failures++;
      $display("FAIL b2b_count: got %0d bytes required %0d", rx_q.size() - base, 2 * MSG_LEN);
    end else begin
      for (int i = 0; i < 2 * MSG_LEN; i++) begin
        checks++;
        if (rx_q[base+i] !== {1'b1, exp_byte(i < MSG_LEN ? a : c, i % MSG_LEN)}) begin
          failures++;
          $display("FAIL b2b_byte %0d: got %h required %h", i, rx_q[base+i], {1'b1, exp_byte(i < MSG_LEN ? a : c, i % MSG_LEN)});
        end
      end
      checks++;
      if (rx_t[base+MSG_LEN] - rx_t[base] != MSG) begin
        failures++;
        $display("FAIL b2b_gap: got %0d cycles between messages required %0d", rx_t[base+MSG_LEN] - rx_t[base], MSG);
      end
    end
  endtask

  task automatic test_reset_mid();
    sample_in = 8'hA5;
    sample_rdy = 1'b1;
    step(1);
    sample_rdy = 1'b0;
    step(55);
    checks++;
    if ({serial_out, busy} !== 2'b01) begin
      failures++;
      $display("FAIL mid_bit4: got line/busy=%b required 01", {serial_out, busy});
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({serial_out, busy} !== 2'b10) begin
      failures++;
      $display("FAIL mid_async_reset: got line/busy=%b required 10", {serial_out, busy});
    end
    step(3);
    rstn = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step(1);
      checks++;
      if ({serial_out, busy} !== 2'b10) begin
        failures++;
        $display("FAIL mid_after_release k=%0d: got line/busy=%b required 10", k, {serial_out, busy});
      end
    end
  endtask

  // Model: the transmitter frees at the end of each message and takes whatever is pending then.
  task automatic test_random(input int n, input int gmin, input int gmax);
    int cap_e[$], exp_t[$];
    logic [7:0] cap_v[$], exp_v[$], bufv;
    int base, ov0, ov_exp, end_e, t, j, horizon;
    logic full, tk, rs;
    base = rx_q.size();
    ov0 = ov_cnt;
    ov_exp = 0;
    full = 1'b0;
    bufv = 8'h00;
    j = 0;
    t = cyc;
    end_e = cyc;
    for (int i = 0; i < n; i++) begin
      t += $urandom_range(gmax, gmin);
      cap_e.push_back(t);
      cap_v.push_back(8'($urandom));
    end
    horizon = t + 2 * MSG + 100;
    for (int e = cyc + 1; e <= horizon; e++) begin
      rs = j < n && cap_e[j] == e;
      sample_rdy = rs;
      if (rs) sample_in = cap_v[j];
      tk = full && e >= end_e;
      if (tk) begin
        exp_v.push_back(bufv);
        exp_t.push_back(e);
        end_e = e + MSG;
      end
      if (rs) begin
        if (full && !tk) ov_exp++;
        bufv = cap_v[j];
        full = 1'b1;
        j++;
      end else if (tk) full = 1'b0;
      step(1);
    end
    sample_rdy = 1'b0;
    checks++;
    if (ov_cnt - ov0 != ov_exp) begin
      failures++;
      $display("FAIL rand_overrun: got %0d required %0d", ov_cnt - ov0, ov_exp);
    end
    checks++;
    if (rx_q.size() - base != exp_v.size() * MSG_LEN) begin
      failures++;
      $display("FAIL rand_count: got %0d bytes required %0d", rx_q.size() - base, exp_v.size() * MSG_LEN);
    end else
      for (int i = 0; i < exp_v.size(); i++) begin
        checks++;
        if (rx_t[base+i*MSG_LEN] != exp_t[i]) begin
          failures++;
          $display("FAIL rand_start msg %0d: got cycle %0d required %0d", i, rx_t[base+i*MSG_LEN], exp_t[i]);
        end
        for (int k = 0; k < MSG_LEN; k++) begin
          checks++;
          if (rx_q[base+i*MSG_LEN+k] !== {1'b1, exp_byte(exp_v[i], k)}) begin
            failures++;
            $display("FAIL rand_byte msg %0d byte %0d: got %h required %h", i, k, rx_q[base+i*MSG_LEN+k], {1'b1, exp_byte(exp_v[i], k)});
          end
        end
      end
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_frame(8'($urandom));
    test_frame(8'($urandom));
    test_level(8'h3C);
    test_level(8'($urandom));
    test_back_to_back(8'h11, 8'h22, 8'h33);
    test_back_to_back(8'($urandom), 8'($urandom), 8'($urandom));
    test_reset_mid();
    test_random(10, 2, 40);
    test_random(8, 60, 250);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
